// File: rtl/trap_unit.sv
// trap_unit: turns committing exceptions, mret and a synchronized external
// interrupt into trap-side CSR write cycles, then issues a one-cycle PC redirect.
module trap_unit #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic [31:0] commit_inst,
    input  logic [31:0] mem_addr,
    input  logic        exc_inst_misaligned,
    input  logic        exc_illegal,
    input  logic        exc_ecall,
    input  logic        exc_ebreak,
    input  logic        exc_load_fault,
    input  logic        exc_store_fault,
    input  logic        mret_inst,
    input  logic        ext_irq,
    input  logic [31:0] mstatus,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_r,
    output logic        kill,
    output logic        flush,
    output logic        trap_csr_w,
    output logic        exception_unit_flag,
    output logic        mret,
    output logic [31:0] mcause_w,
    output logic [31:0] mtval_w,
    output logic [31:0] mepc_w,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StTrap, StMret, StRedir} state_e;

    state_e      state_q;
    logic        irq_meta_q, irq_s_q;
    logic        flush_q, trap_csr_w_q, exc_flag_q, mret_q, redirect_q;
    logic        redir_mret_q;
    logic [31:0] mcause_q, mtval_q, mepc_q;

    logic        is_idle;
    logic        trap_cond;
    logic [31:0] cause_d, tval_d;
    logic [31:0] tvec_base, tvec_vect;

    // Only bit 3 (MIE) of mstatus matters here.
    logic unused_mstatus;
    assign unused_mstatus = ^{mstatus[31:4], mstatus[2:0]};

    // Two-flop synchronizer for the asynchronous external interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_meta_q <= 1'b0;
            irq_s_q    <= 1'b0;
        end else begin
            irq_meta_q <= ext_irq;
            irq_s_q    <= irq_meta_q;
        end
    end

    // Prioritised trap cause and tval selection for the committing instruction.
    always_comb begin
        trap_cond = 1'b1;
        cause_d   = 32'd0;
        tval_d    = 32'd0;
        if (irq_s_q && mstatus[3]) begin
            cause_d = 32'h8000_000B;
        end else if (exc_inst_misaligned) begin
            cause_d = 32'd0;
            tval_d  = commit_pc;
        end else if (exc_illegal) begin
            cause_d = 32'd2;
            tval_d  = commit_inst;
        end else if (exc_ecall) begin
            cause_d = 32'd11;
        end else if (exc_ebreak) begin
            cause_d = 32'd3;
        end else if (exc_load_fault) begin
            cause_d = 32'd5;
            tval_d  = mem_addr;
        end else if (exc_store_fault) begin
            cause_d = 32'd7;
            tval_d  = mem_addr;
        end else begin
            trap_cond = 1'b0;
        end
    end

    assign is_idle = (state_q == StIdle);
    assign kill    = is_idle & commit_valid & (trap_cond | mret_inst);

    // Trap FSM with registered strobes and latched trap CSR data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            flush_q      <= 1'b0;
            trap_csr_w_q <= 1'b0;
            exc_flag_q   <= 1'b0;
            mret_q       <= 1'b0;
            redirect_q   <= 1'b0;
            redir_mret_q <= 1'b0;
            mcause_q     <= 32'd0;
            mtval_q      <= 32'd0;
            mepc_q       <= RESET_PC;
        end else begin
            flush_q      <= 1'b0;
            trap_csr_w_q <= 1'b0;
            exc_flag_q   <= 1'b0;
            mret_q       <= 1'b0;
            redirect_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (commit_valid && trap_cond) begin
                        state_q      <= StTrap;
                        flush_q      <= 1'b1;
                        trap_csr_w_q <= 1'b1;
                        exc_flag_q   <= 1'b1;
                        redir_mret_q <= 1'b0;
                        mcause_q     <= cause_d;
                        mtval_q      <= tval_d;
                        mepc_q       <= commit_pc;
                    end else if (commit_valid && mret_inst) begin
                        state_q      <= StMret;
                        flush_q      <= 1'b1;
                        trap_csr_w_q <= 1'b1;
                        mret_q       <= 1'b1;
                        redir_mret_q <= 1'b1;
                    end
                end
                StTrap, StMret: begin
                    state_q    <= StRedir;
                    flush_q    <= 1'b1;
                    redirect_q <= 1'b1;
                end
                StRedir: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Target is computed from live mtvec/mepc_r so the CSR write of the previous
    // cycle is already visible.
    assign tvec_base = {mtvec[31:2], 2'b00};
    assign tvec_vect = tvec_base + {mcause_q[29:0], 2'b00};

    always_comb begin
        redirect_pc = RESET_PC;
        if (state_q == StRedir) begin
            if (redir_mret_q) begin
                redirect_pc = {mepc_r[31:2], 2'b00};
            end else if (mtvec[1:0] == 2'b01 && mcause_q[31]) begin
                redirect_pc = tvec_vect;
            end else begin
                redirect_pc = tvec_base;
            end
        end
    end

    assign flush               = flush_q;
    assign trap_csr_w          = trap_csr_w_q;
    assign exception_unit_flag = exc_flag_q;
    assign mret                = mret_q;
    assign redirect            = redirect_q;
    assign mcause_w            = mcause_q;
    assign mtval_w             = mtval_q;
    assign mepc_w              = mepc_q;
    assign busy                = ~is_idle;

endmodule
